prog_loader: RTL and testbench

//  Host-side front end of the processor: accepts a 9-bit machine-code stream,

---
 rtl/prog_loader_if.sv | 40 ++++
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Host-stream / instruction-memory / core-handshake bundle for prog_loader.
// slave  : the loader itself.
// master : the environment (host, instruction memory, core).
//
// Handshake semantics: a stream word transfers on any rising clk edge where
// ld_valid && ld_ready are both 1; the host must keep ld_data/ld_last stable
// while ld_valid is high. core_req is a one-cycle start pulse; core_done is
// level-sampled only while the core runs. done is held until done_ack is seen.
interface prog_loader_if #(
  parameter int D  = 12,
  parameter int IW = 9,
  parameter int CW = 32
) ();
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          imem_wr_en;
  logic [D-1:0]  imem_wr_addr;
  logic [IW-1:0] imem_wr_data;
  logic          core_req;
  logic          core_done;
  logic          done;
  logic          done_ack;
  logic [D:0]    prog_len;
  logic [CW-1:0] cyc_cnt;
  logic          err;

  modport slave (
    input  ld_valid, ld_data, ld_last, core_done, done_ack,
    output ld_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
           core_req, done, prog_len, cyc_cnt, err
  );

  modport master (
    output ld_valid, ld_data, ld_last, core_done, done_ack,
    input  ld_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
           core_req, done, prog_len, cyc_cnt, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory from address 0,
// starts the core with a one-cycle req pulse, counts RUN cycles until the
// core reports done, then holds done until the host acknowledges.
// Optional feature: define LOADER_WDOG_EN to abort RUN after WDOG_LIMIT
// cycles without core_done (sets err).
module prog_loader #(
  parameter int D          = 12,
  parameter int IW         = 9,
  parameter int CW         = 32,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave ld,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Word count equal to the memory depth: no address left to write.
  localparam logic [D:0] FULL = {1'b1, {D{1'b0}}};

  state_e        state_q, state_d;
  logic [D:0]    count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [D-1:0]  wr_addr_q, wr_addr_d;
  logic [IW-1:0] wr_data_q, wr_data_d;
  logic [D:0]    prog_len_q, prog_len_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic          err_q, err_d;
  logic          beat;
  logic          wdog_hit;

  assign ld.ld_ready    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign beat           = ld.ld_valid && ld.ld_ready;
  assign ld.core_req    = (state_q == S_ARM);
  assign ld.done        = (state_q == S_DONE);
  assign ld.imem_wr_en   = wr_en_q;
  assign ld.imem_wr_addr = wr_addr_q;
  assign ld.imem_wr_data = wr_data_q;
  assign ld.prog_len    = prog_len_q;
  assign ld.cyc_cnt     = cyc_cnt_q;
  assign ld.err         = err_q;
  assign dbg_state_o    = state_q;

`ifdef LOADER_WDOG_EN
  // Watchdog trips once the RUN counter has reached the limit.
  assign wdog_hit = (cyc_cnt_q >= CW'(WDOG_LIMIT));
`else
  assign wdog_hit = 1'b0;
`endif

  // State and datapath registers; memory contents are never cleared here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      prog_len_q <= '0;
      cyc_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      prog_len_q <= prog_len_d;
      cyc_cnt_q  <= cyc_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    prog_len_d = prog_len_q;
    cyc_cnt_d  = cyc_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          err_d     = 1'b0;
          cyc_cnt_d = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = ld.ld_data;
          count_d   = {{D{1'b0}}, 1'b1};
          state_d   = ld.ld_last ? S_ARM : S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (count_q == FULL) begin
            // Memory already full: a further word has no address, so it is
            // dropped (even if flagged last) and the core is never started.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[D-1:0];
            wr_data_d = ld.ld_data;
            count_d   = count_q + 1'b1;
            if (ld.ld_last) state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        // core_done is deliberately not looked at here.
        prog_len_d = count_q;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (ld.core_done) begin
          state_d = S_DONE;
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cyc_cnt_q != {CW{1'b1}}) begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (ld.done_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader (D=3 so the overflow path is reachable quickly).
module tb_prog_loader;
  localparam int D    = 3;
  localparam int IW   = 9;
  localparam int CW   = 32;
  localparam int WDOG = 20;
  localparam int SBW  = 32 + D + IW;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader_if #(.D(D), .IW(IW), .CW(CW)) bus ();

  prog_loader #(.D(D), .IW(IW), .CW(CW), .WDOG_LIMIT(WDOG)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld          (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // Entry: {expected write cycle, address, data}
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] mon_e;
  int n_checks = 0;
  int n_errors = 0;
  int req_cnt  = 0;
  int exp_req  = 0;
  int m_count  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every imem write must match the head of the queue.
  always @(negedge clk) begin
    if (reset && bus.imem_wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", bus.imem_wr_en, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(mon_e[SBW-1 -: 32]));
        check("wr_addr", 64'(bus.imem_wr_addr), 64'(mon_e[D+IW-1 -: D]));
        check("wr_data", 64'(bus.imem_wr_data), 64'(mon_e[IW-1:0]));
      end
    end
    if (reset && bus.core_req) req_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [IW-1:0] data, input logic last);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_data  = data;
    bus.ld_last  = last;
    check("ld_ready", bus.ld_ready, 1'b1);
    if (m_count < (1 << D)) begin
      exp_q.push_back({32'(cyc + 1), D'(m_count), data});
      m_count++;
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_wait", bus.done, 1'b1);
  endtask

  task automatic ack_done();
    bus.done_ack = 1'b1;
    @(negedge clk);
    bus.done_ack = 1'b0;
    check("ack_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("ack_done0", bus.done, 1'b0);
    check("ack_ready", bus.ld_ready, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, bus.imem_wr_en, 1'b0);
    check({tag, "_wr_addr"}, 64'(bus.imem_wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(bus.imem_wr_data), 64'd0);
    check({tag, "_req"}, bus.core_req, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
    check({tag, "_len"}, 64'(bus.prog_len), 64'd0);
    check({tag, "_cyc"}, 64'(bus.cyc_cnt), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    check({tag, "_ready"}, bus.ld_ready, 1'b1);
  endtask

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int len;
    int n;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    bus.core_done = 1'b0;
    bus.done_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;

    // Three-word program, then 10 RUN cycles.
    m_count = 0;
    drive_beat(9'h1A0, 1'b0);
    drive_beat(9'h0F3, 1'b0);
    drive_beat(9'h1FF, 1'b1);
    idle_cycle();
    exp_req++;
    check("p3_arm", 64'(dbg_state), 64'(ST_ARM));
    check("p3_req", bus.core_req, 1'b1);
    @(negedge clk);
    check("p3_req_off", bus.core_req, 1'b0);
    check("p3_run", 64'(dbg_state), 64'(ST_RUN));
    check("p3_len", 64'(bus.prog_len), 64'd3);
    repeat (10) @(negedge clk);
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    check("p3_done", bus.done, 1'b1);
    check("p3_cyc", 64'(bus.cyc_cnt), 64'd10);
    check("p3_err", bus.err, 1'b0);
    repeat (2) @(negedge clk);
    check("p3_done_held", bus.done, 1'b1);
    check("p3_reqcnt", 64'(req_cnt), 64'(exp_req));
    ack_done();
    check("p3_len_hold", 64'(bus.prog_len), 64'd3);
    check("p3_cyc_hold", 64'(bus.cyc_cnt), 64'd10);

    // Single last word; core_done in ARM must be ignored.
    m_count = 0;
    drive_beat(9'h055, 1'b1);
    idle_cycle();
    exp_req++;
    check("p1_arm", 64'(dbg_state), 64'(ST_ARM));
    check("p1_cyc_clr", 64'(bus.cyc_cnt), 64'd0);
    bus.core_done = 1'b1;
    @(negedge clk);
    check("p1_arm_ignores_done", 64'(dbg_state), 64'(ST_RUN));
    check("p1_len", 64'(bus.prog_len), 64'd1);
    @(negedge clk);
    bus.core_done = 1'b0;
    check("p1_done", bus.done, 1'b1);
    check("p1_cyc", 64'(bus.cyc_cnt), 64'd0);
    ack_done();

    // Overflow: 9 beats, none last, into an 8-word memory.
    m_count = 0;
    for (int i = 0; i < 9; i++) drive_beat(IW'($urandom_range(0, 511)), 1'b0);
    idle_cycle();
    check("ovf_state", 64'(dbg_state), 64'(ST_DONE));
    check("ovf_done", bus.done, 1'b1);
    check("ovf_err", bus.err, 1'b1);
    check("ovf_reqcnt", 64'(req_cnt), 64'(exp_req));
    check("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
    ack_done();
    check("ovf_err_hold", bus.err, 1'b1);
    check("ovf_len_hold", 64'(bus.prog_len), 64'd1);

    // Random programs with gaps and random run lengths.
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(1, 8);
      m_count = 0;
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 2) == 0) idle_cycle();
        drive_beat(IW'($urandom_range(0, 511)), k == len - 1);
      end
      idle_cycle();
      exp_req++;
      check("rnd_arm", 64'(dbg_state), 64'(ST_ARM));
      check("rnd_err_clr", bus.err, 1'b0);
      @(negedge clk);
      check("rnd_len", 64'(bus.prog_len), 64'(len));
      n = $urandom_range(0, 15);
      repeat (n) @(negedge clk);
      bus.core_done = 1'b1;
      @(negedge clk);
      bus.core_done = 1'b0;
      check("rnd_done", bus.done, 1'b1);
      check("rnd_cyc", 64'(bus.cyc_cnt), 64'(n));
      ack_done();
    end
    check("rnd_reqcnt", 64'(req_cnt), 64'(exp_req));

    // Core that never finishes.
    m_count = 0;
    drive_beat(9'h1C3, 1'b1);
    idle_cycle();
    exp_req++;
    @(negedge clk);
    check("wd_run", 64'(dbg_state), 64'(ST_RUN));
`ifdef LOADER_WDOG_EN
    wait_done(60);
    check("wd_err", bus.err, 1'b1);
    check("wd_cyc", 64'(bus.cyc_cnt), 64'(WDOG));
    bus.core_done = 1'b1;
    repeat (2) @(negedge clk);
    bus.core_done = 1'b0;
    check("wd_late_done", 64'(dbg_state), 64'(ST_DONE));
    ack_done();
    m_count = 0;
    drive_beat(9'h0AA, 1'b1);
    idle_cycle();
    exp_req++;
    @(negedge clk);
    check("rr_run", 64'(dbg_state), 64'(ST_RUN));
`else
    repeat (60) @(negedge clk);
    check("nowd_done", bus.done, 1'b0);
    check("nowd_state", 64'(dbg_state), 64'(ST_RUN));
    check("nowd_cyc", 64'(bus.cyc_cnt), 64'd60);
`endif

    // Asynchronous reset in RUN, mid-cycle.
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    bus.core_done = 1'b1;
    repeat (3) @(negedge clk);
    bus.core_done = 1'b0;
    check("post_rst_done", bus.done, 1'b0);
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("post_rst_ready", bus.ld_ready, 1'b1);
    check("post_rst_reqcnt", 64'(req_cnt), 64'(exp_req));
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
